dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory: a 32-bit word array, 256 words, with a synchronous write and a combinational read gated by mem_read.
- Port 0 is the pipeline MEM stage. Port 1 is the debug/loader port.
- Grants one requester at a time with round-robin fairness and latches the command.
- Drives the memory strobes for exactly one cycle, then returns a done pulse, read data and an error flag to the owner.

Parameters:
- MEM_DEPTH, 256, number of words in the memory; word addresses >= MEM_DEPTH are out of range.
- DATA_W, 32, width of the data bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request; held until gnt0.
- we0  input  1  port 0: 1 = write, 0 = read.
- addr0  input  32  port 0 word address.
- wdata0  input  DATA_W  port 0 write data.
- gnt0  output  1  combinational; the port 0 command is accepted this cycle.
- done0  output  1  one-cycle pulse: port 0 access complete.
- rdata0  output  DATA_W  port 0 read data; valid while done0 is high.
- err0  output  1  out-of-range flag for port 0; valid while done0 is high.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1, err1: same meaning, for port 1.
- stall  output  1  equals req0 & ~gnt0; stalls the pipeline.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- address  output  32  memory word address.
- write_data  output  DATA_W  memory write data.
- read_data  input  DATA_W  combinational read data from the memory.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async, rst_n = 0): state = IDLE and last_owner = 1, so port 0 wins first.
- Outputs during reset: gnt*, done*, err*, mem_read and mem_write are 0; rdata*, address and write_data are 0.
- Acceptance: in IDLE or RESP, if any req is high, assert gnt to the winner in the same cycle. At the edge, latch owner, we, addr and wdata, set last_owner = winner, and go to ACCESS. If no req is high, go to IDLE.
- Arbitration: if only one port requests, it wins. If both request, the port != last_owner wins (strict alternation). A port must not receive a second grant while the other has been requesting since before that port's previous grant.
- ACCESS (exactly one cycle):
  - address = latched addr and write_data = latched wdata.
  - If latched addr < MEM_DEPTH: mem_write = we and mem_read = ~we.
  - If latched addr >= MEM_DEPTH: both strobes are 0 and the error bit is set.
  - At the edge: capture read_data into the response register (capture 0 for writes and for errors), then go to RESP.
- RESP (one cycle):
  - done[owner] = 1.
  - rdata[owner] = captured data; reads only, 0 for writes and for errors.
  - err[owner] = error bit.
  - New requests may be granted in this same cycle, so back-to-back throughput is one access per 2 cycles.
- Latency: a request granted in cycle N produces memory strobes in cycle N+1 and done in cycle N+2.
- Outputs outside their valid states: done, rdata and err of the non-owner port are 0. address, write_data and both strobes are 0 outside ACCESS.
- Requester rule: req/we/addr/wdata are sampled only on the gnt cycle. Changes after the grant have no effect on the access in flight.
- Simultaneous events: a request arriving during ACCESS waits, with no grant, until RESP. A req deasserted before its grant is simply dropped.
- Reset mid-operation: an in-flight access is abandoned. No done pulse is issued, and a write in ACCESS is not committed once rst_n is low, because the strobes are forced to 0.
- Width rules: the address is compared as an unsigned 32-bit value. There is no byte or halfword support; all accesses are full words.

Test Plan:
- Port 0 write then read:
  - req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF → gnt0 in cycle 0; mem_write = 1 with address 0x10 in cycle 1; done0 = 1, err0 = 0 in cycle 2.
  - Then a read of 0x10 → done0 with rdata0 = 0xDEADBEEF.
- Contention:
  - req0 and req1 held high together, reading addresses 0x1 and 0x2 → grants in order port 0, port 1, port 0, port 1.
  - Grants are 2 cycles apart; stall is 1 in every cycle in which req0 is high without gnt0.
- Out of range: port 1 write to address 256 → mem_write stays 0; done1 = 1, err1 = 1, rdata1 = 0; memory word 0 is unchanged.
- Late request: req1 raised during the ACCESS of a port 0 access → gnt1 is asserted in the RESP cycle together with done0 = 1; the port 1 access follows immediately.
- Reset mid-access: rst_n driven low during the ACCESS of a write of 0x12345678 to 0x20 → all outputs go to 0 at once, there is no done pulse, and a later read of 0x20 returns the prior contents.
- Idle: no requests for 10 cycles → all outputs stay 0 and state stays IDLE; after that, req1 alone is granted immediately in the first cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side signals of the data-memory arbiter
//   req/we/addr/wdata{0,1}   : requester commands (port 0 = MEM stage, port 1 = debug/loader)
//   gnt/done/rdata/err{0,1}  : grant and response back to each requester
//   stall                    : pipeline stall (req0 & ~gnt0)
//   mem_read/mem_write/address/write_data/read_data : single-port data memory
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0, we0, gnt0, done0, err0;
    logic [31:0]       addr0;
    logic [DATA_W-1:0] wdata0, rdata0;
    logic              req1, we1, gnt1, done1, err1;
    logic [31:0]       addr1;
    logic [DATA_W-1:0] wdata1, rdata1;
    logic              stall, mem_read, mem_write;
    logic [31:0]       address;
    logic [DATA_W-1:0] write_data, read_data;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, read_data,
        output gnt0, done0, err0, rdata0, gnt1, done1, err1, rdata1,
        output stall, mem_read, mem_write, address, write_data
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, read_data,
        input  gnt0, done0, err0, rdata0, gnt1, done1, err1, rdata1,
        input  stall, mem_read, mem_write, address, write_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and sequencer for a single-port data memory
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave carrying both requester ports and the memory strobes
// Each access takes IDLE/RESP (grant) -> ACCESS (strobes) -> RESP (done), so a new
// grant can overlap the RESP cycle and throughput is one access per two cycles.
module dmem_arbiter #(
    parameter int MEM_DEPTH = 256,
    parameter int DATA_W    = 32
) (
    input logic            clk,
    input logic            rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              take, win, in_range;
    logic              owner, last_owner, lat_we, err_q;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata, rsp_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        // rst_n gating keeps grants low while reset is held even with requests pending
        take      = rst_n && (state != ACCESS) && (bus.req0 || bus.req1);
        // on contention the port that did not win last time goes next
        win       = (bus.req0 && bus.req1) ? ~last_owner : bus.req1;
        in_range  = lat_addr < 32'(MEM_DEPTH);
        state_nxt = take ? ACCESS : (state == ACCESS) ? RESP : IDLE;
        bus.gnt0  = take && !win;
        bus.gnt1  = take && win;
        bus.stall = bus.req0 && !bus.gnt0;
        bus.mem_read   = (state == ACCESS) && in_range && !lat_we;
        bus.mem_write  = (state == ACCESS) && in_range && lat_we;
        bus.address    = (state == ACCESS) ? lat_addr : '0;
        bus.write_data = (state == ACCESS) ? lat_wdata : '0;
        bus.done0  = (state == RESP) && !owner;
        bus.done1  = (state == RESP) && owner;
        bus.rdata0 = bus.done0 ? rsp_data : '0;
        bus.rdata1 = bus.done1 ? rsp_data : '0;
        bus.err0   = bus.done0 && err_q;
        bus.err1   = bus.done1 && err_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            err_q      <= 1'b0;
            rsp_data   <= '0;
        end else begin
            if (take) begin
                owner      <= win;
                last_owner <= win;
                lat_we     <= win ? bus.we1    : bus.we0;
                lat_addr   <= win ? bus.addr1  : bus.addr0;
                lat_wdata  <= win ? bus.wdata1 : bus.wdata0;
            end
            if (state == ACCESS) begin
                rsp_data <= (in_range && !lat_we) ? bus.read_data : '0;
                err_q    <= !in_range;
            end
        end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural 256-word memory
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(32)) bus();
    dmem_arbiter #(.MEM_DEPTH(256), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    bit [31:0] mem [256];
    always @(posedge clk) if (bus.mem_write) mem[bus.address[7:0]] <= bus.write_data;
    assign bus.read_data = bus.mem_read ? mem[bus.address[7:0]] : 32'h0;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] rd;
    logic        er;
    bit          ok;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    endtask

    // Runs one complete access on port p from an idle/RESP cycle; ok = granted within budget and done seen
    task automatic access(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdo, output logic ero, output bit oko);
        oko = 0;
        if (p) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        else   begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
        for (int i = 0; i < 10 && !oko; i++) begin
            @(negedge clk);
            oko = p ? bus.gnt1 : bus.gnt0;
            if (!oko) tick();
        end
        tick();
        if (p) bus.req1 = 0; else bus.req0 = 0;
        tick();
        @(negedge clk);
        oko  = oko && (p ? bus.done1 : bus.done0);
        rdo  = p ? bus.rdata1 : bus.rdata0;
        ero  = p ? bus.err1 : bus.err0;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        bus.req0 = 1; bus.req1 = 1; bus.we0 = 1; bus.addr0 = 32'h5;
        @(negedge clk);
        compared++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.mem_read, bus.mem_write} !== 8'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.mem_read, bus.mem_write});
        end
        compared++;
        if ({bus.address, bus.write_data, bus.rdata0, bus.rdata1} !== 128'h0) begin
            mismatched++;
            $display("FAIL reset_data: got addr=%h wd=%h rd0=%h rd1=%h expected all 0",
                     bus.address, bus.write_data, bus.rdata0, bus.rdata1);
        end
        clear_inputs();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_write_read;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        compared++;
        if ({bus.gnt0, bus.gnt1, bus.stall, bus.mem_write} !== 4'b1000) begin
            mismatched++;
            $display("FAIL wr_c0: gnt0,gnt1,stall,mem_write got %b expected 1000",
                     {bus.gnt0, bus.gnt1, bus.stall, bus.mem_write});
        end
        tick();
        bus.req0 = 0; bus.addr0 = 32'h55; bus.wdata0 = 32'h0BAD0BAD;
        @(negedge clk);
        compared++;
        if ({bus.mem_write, bus.mem_read, bus.done0, bus.address, bus.write_data} !== {3'b100, 32'h10, 32'hDEADBEEF}) begin
            mismatched++;
            $display("FAIL wr_c1: mw=%b mr=%b done0=%b addr=%h wd=%h expected 1 0 0 00000010 deadbeef",
                     bus.mem_write, bus.mem_read, bus.done0, bus.address, bus.write_data);
        end
        tick();
        @(negedge clk);
        compared++;
        if ({bus.done0, bus.err0, bus.done1, bus.mem_write, bus.rdata0} !== {4'b1000, 32'h0}) begin
            mismatched++;
            $display("FAIL wr_c2: done0=%b err0=%b done1=%b mw=%b rdata0=%h expected 1 0 0 0 00000000",
                     bus.done0, bus.err0, bus.done1, bus.mem_write, bus.rdata0);
        end
        tick();
        access(0, 0, 32'h10, 0, rd, er, ok);
        compared++;
        if ({ok, er, rd} !== {2'b10, 32'hDEADBEEF}) begin
            mismatched++;
            $display("FAIL rd_back: ok=%b err=%b rdata=%h expected 1 0 deadbeef", ok, er, rd);
        end
    endtask

    task automatic test_contention;
        logic [7:0] eg0 = 8'b0001_0001;
        logic [7:0] eg1 = 8'b0100_0100;
        logic [7:0] est = 8'b0110_1110;
        access(0, 1, 32'h1, 32'h11111111, rd, er, ok);
        access(1, 1, 32'h2, 32'h22222222, rd, er, ok);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h1;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h2;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin bus.req0 = 0; bus.req1 = 0; end
            @(negedge clk);
            compared++;
            if ({bus.gnt0, bus.gnt1, bus.stall} !== {eg0[i], eg1[i], est[i]}) begin
                mismatched++;
                $display("FAIL contend_c%0d: gnt0,gnt1,stall got %b expected %b",
                         i, {bus.gnt0, bus.gnt1, bus.stall}, {eg0[i], eg1[i], est[i]});
            end
            if (i == 2) begin
                compared++;
                if ({bus.done0, bus.done1, bus.rdata0} !== {2'b10, 32'h11111111}) begin
                    mismatched++;
                    $display("FAIL contend_done0: done0=%b done1=%b rdata0=%h expected 1 0 11111111",
                             bus.done0, bus.done1, bus.rdata0);
                end
            end
            if (i == 4) begin
                compared++;
                if ({bus.done0, bus.done1, bus.rdata1} !== {2'b01, 32'h22222222}) begin
                    mismatched++;
                    $display("FAIL contend_done1: done0=%b done1=%b rdata1=%h expected 0 1 22222222",
                             bus.done0, bus.done1, bus.rdata1);
                end
            end
            tick();
        end
        tick();
    endtask

    task automatic test_out_of_range;
        access(0, 1, 32'h0, 32'hCAFEF00D, rd, er, ok);
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'd256; bus.wdata1 = 32'hBADBAD00;
        @(negedge clk);
        compared++;
        if (bus.gnt1 !== 1'b1) begin
            mismatched++;
            $display("FAIL oor_gnt1: got %b expected 1", bus.gnt1);
        end
        tick();
        bus.req1 = 0;
        @(negedge clk);
        compared++;
        if ({bus.mem_write, bus.mem_read, bus.address} !== {2'b00, 32'd256}) begin
            mismatched++;
            $display("FAIL oor_strobe: mw=%b mr=%b addr=%h expected 0 0 00000100",
                     bus.mem_write, bus.mem_read, bus.address);
        end
        tick();
        @(negedge clk);
        compared++;
        if ({bus.done1, bus.err1, bus.done0, bus.err0, bus.rdata1} !== {4'b1100, 32'h0}) begin
            mismatched++;
            $display("FAIL oor_resp: done1=%b err1=%b done0=%b err0=%b rdata1=%h expected 1 1 0 0 00000000",
                     bus.done1, bus.err1, bus.done0, bus.err0, bus.rdata1);
        end
        tick();
        access(0, 0, 32'h0, 0, rd, er, ok);
        compared++;
        if ({ok, er, rd} !== {2'b10, 32'hCAFEF00D}) begin
            mismatched++;
            $display("FAIL oor_word0: ok=%b err=%b rdata=%h expected 1 0 cafef00d", ok, er, rd);
        end
        access(1, 0, 32'hFFFFFFFF, 0, rd, er, ok);
        compared++;
        if ({ok, er, rd} !== {2'b11, 32'h0}) begin
            mismatched++;
            $display("FAIL oor_max_read: ok=%b err=%b rdata=%h expected 1 1 00000000", ok, er, rd);
        end
        access(1, 1, 32'd255, 32'h5A5A5A5A, rd, er, ok);
        access(0, 0, 32'd255, 0, rd, er, ok);
        compared++;
        if ({ok, er, rd} !== {2'b10, 32'h5A5A5A5A}) begin
            mismatched++;
            $display("FAIL last_word: ok=%b err=%b rdata=%h expected 1 0 5a5a5a5a", ok, er, rd);
        end
    endtask

    task automatic test_late_request;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h10;
        @(negedge clk);
        tick();
        bus.req0 = 0;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h2;
        @(negedge clk);
        compared++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            mismatched++;
            $display("FAIL late_access_gnt: gnt0,gnt1 got %b expected 00", {bus.gnt0, bus.gnt1});
        end
        tick();
        @(negedge clk);
        compared++;
        if ({bus.done0, bus.gnt1, bus.rdata0} !== {2'b11, 32'hDEADBEEF}) begin
            mismatched++;
            $display("FAIL late_resp: done0=%b gnt1=%b rdata0=%h expected 1 1 deadbeef",
                     bus.done0, bus.gnt1, bus.rdata0);
        end
        tick();
        bus.req1 = 0;
        @(negedge clk);
        compared++;
        if ({bus.mem_read, bus.address} !== {1'b1, 32'h2}) begin
            mismatched++;
            $display("FAIL late_follow: mr=%b addr=%h expected 1 00000002", bus.mem_read, bus.address);
        end
        tick();
        @(negedge clk);
        compared++;
        if ({bus.done1, bus.rdata1} !== {1'b1, 32'h22222222}) begin
            mismatched++;
            $display("FAIL late_done1: done1=%b rdata1=%h expected 1 22222222", bus.done1, bus.rdata1);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        access(0, 1, 32'h20, 32'hAAAA5555, rd, er, ok);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h20; bus.wdata0 = 32'h12345678;
        @(negedge clk);
        tick();
        bus.req0 = 0;
        #1 rst_n = 0;
        @(negedge clk);
        compared++;
        if ({bus.mem_write, bus.mem_read, bus.done0, bus.gnt0, bus.address, bus.write_data} !== {4'b0, 64'h0}) begin
            mismatched++;
            $display("FAIL rstmid_out: mw=%b mr=%b done0=%b gnt0=%b addr=%h wd=%h expected all 0",
                     bus.mem_write, bus.mem_read, bus.done0, bus.gnt0, bus.address, bus.write_data);
        end
        tick();
        rst_n = 1;
        @(negedge clk);
        compared++;
        if ({bus.done0, bus.done1, bus.mem_write} !== 3'b000) begin
            mismatched++;
            $display("FAIL rstmid_nodone: done0,done1,mw got %b expected 000", {bus.done0, bus.done1, bus.mem_write});
        end
        tick();
        access(0, 0, 32'h20, 0, rd, er, ok);
        compared++;
        if ({ok, er, rd} !== {2'b10, 32'hAAAA5555}) begin
            mismatched++;
            $display("FAIL rstmid_keep: ok=%b err=%b rdata=%h expected 1 0 aaaa5555", ok, er, rd);
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.stall,
                 bus.mem_read, bus.mem_write, bus.address, bus.write_data, bus.rdata0, bus.rdata1} !== 137'h0) begin
                mismatched++;
                $display("FAIL idle_c%0d: outputs not all zero (addr=%h wd=%h mr=%b mw=%b)",
                         i, bus.address, bus.write_data, bus.mem_read, bus.mem_write);
            end
            tick();
        end
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h2;
        @(negedge clk);
        compared++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            mismatched++;
            $display("FAIL idle_gnt1: gnt0,gnt1 got %b expected 01", {bus.gnt0, bus.gnt1});
        end
        tick();
        bus.req1 = 0;
        tick();
        @(negedge clk);
        compared++;
        if ({bus.done1, bus.rdata1} !== {1'b1, 32'h22222222}) begin
            mismatched++;
            $display("FAIL idle_done1: done1=%b rdata1=%h expected 1 22222222", bus.done1, bus.rdata1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_late_request();
        test_reset_mid();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
